// File: rtl/mem_stage_pkg.sv
// Purpose : shared types and constants for the MEM pipeline stage.
// Latency : n/a (declarations only).
// Backpressure : n/a. Bus widths, stall-vector bit positions, load_op codes, FSM states.
package mem_stage_pkg;

   localparam int EX_TO_MEM_WD = 79;
   localparam int MEM_TO_WB_WD = 70;
   localparam int STALL_WD     = 6;

   // Positions of this stage and the next one in the global stall vector.
   localparam int STALL_MEM = 3;
   localparam int STALL_WB  = 4;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic [2:0] {
      LOAD_LW  = 3'b000,
      LOAD_LB  = 3'b001,
      LOAD_LBU = 3'b010,
      LOAD_LH  = 3'b011,
      LOAD_LHU = 3'b100
   } load_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no load outstanding
      ST_WAIT = 2'd1,   // load in stage, SRAM has not answered yet
      ST_HOLD = 2'd2    // answer captured in buffer, stage held downstream
   } mem_state_e;

   // EX->MEM bundle, MSB first: pc[78:47] ... ex_result[31:0].
   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  load_op;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_to_mem_t;

   // MEM->WB bundle (also the MEM->ID forwarding bundle).
   typedef struct packed {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } mem_to_wb_t;

endpackage

// File: rtl/mem_load_ext.sv
// Purpose : pick the addressed byte/half/word out of an SRAM read word and extend it.
// Latency : combinational.
// Backpressure : none.
// Ports   : load_op (3b code), addr (low two address bits), rdata (raw word, little-endian
//           lanes), ext_data (32-bit extended result). Unknown load_op codes return the word.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [2:0]  load_op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] ext_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      half_sel = rdata[15:0];
      ext_data = rdata;

      case (addr)
         2'b00:   byte_sel = rdata[7:0];
         2'b01:   byte_sel = rdata[15:8];
         2'b10:   byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase

      if (addr[1]) begin
         half_sel = rdata[31:16];
      end

      case (load_op_e'(load_op))
         LOAD_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
         LOAD_LBU: ext_data = {24'h000000, byte_sel};
         LOAD_LH:  ext_data = {{16{half_sel[15]}}, half_sel};
         LOAD_LHU: ext_data = {16'h0000, half_sel};
         default:  ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Purpose : MEM pipeline stage; registers the EX->MEM bus, merges the SRAM read response,
//           extends load data and drives the MEM->WB and MEM->ID buses.
// Latency : one register (EX->MEM); load data used combinationally in the rvalid cycle.
// Backpressure : stall[3]/stall[4] hold or bubble the stage; stallreq_for_mem is raised
//           combinationally while a load in the stage has no data yet.
// Ports   : clk, resetn (async, active-low), stall, ex_to_mem_bus, data_sram_rdata,
//           data_sram_rvalid -> mem_to_wb_bus, mem_to_id_bus, stallreq_for_mem.
// Option  : MEM_ALIGN_CHECK_EN adds mem_adel and suppresses rf_we on misaligned loads.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   input  logic                    data_sram_rvalid,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_WB_WD-1:0] mem_to_id_bus,
   output logic                    stallreq_for_mem
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic                    mem_adel
`endif
);

   ex_to_mem_t stage;
   mem_state_e state;
   mem_state_e state_nxt;
   logic [31:0] load_buf;
   logic        buf_load;
   logic        is_load;
   logic        bubble;
   logic        stage_held;
   logic        stage_moves;
   logic [31:0] load_raw;
   logic [31:0] load_data;
   logic        misaligned;
   logic        rf_we_out;
   mem_to_wb_t  wb;

   assign bubble      = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);
   assign stage_held  = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == STOP);
   // The register contents change (advance or bubble), so any load in it is gone.
   assign stage_moves = !stage_held;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stage <= '0;
      end else if (bubble) begin
         stage <= '0;
      end else if (stall[STALL_MEM] == NO_STOP) begin
         stage <= ex_to_mem_t'(ex_to_mem_bus);
      end
   end

   assign is_load = stage.data_ram_en && (stage.data_ram_wen == 4'b0000);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         load_buf <= '0;
      end else begin
         state <= state_nxt;
         if (buf_load) begin
            load_buf <= data_sram_rdata;
         end
      end
   end

   // A load whose data arrives while the stage is held keeps that data in load_buf,
   // because the SRAM only presents it for one cycle.
   always_comb begin
      state_nxt = state;
      buf_load  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_load && !stage_moves) begin
               if (data_sram_rvalid) begin
                  state_nxt = ST_HOLD;
                  buf_load  = 1'b1;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (stage_moves) begin
               state_nxt = ST_IDLE;
            end else if (data_sram_rvalid) begin
               state_nxt = ST_HOLD;
               buf_load  = 1'b1;
            end
         end
         ST_HOLD: begin
            if (stage_moves) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign stallreq_for_mem = is_load && !data_sram_rvalid && (state != ST_HOLD);

   assign load_raw = (state == ST_HOLD) ? load_buf : data_sram_rdata;

   mem_load_ext u_load_ext (
      .load_op  (stage.load_op),
      .addr     (stage.ex_result[1:0]),
      .rdata    (load_raw),
      .ext_data (load_data)
   );

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      misaligned = 1'b0;
      if (is_load) begin
         case (load_op_e'(stage.load_op))
            LOAD_LB, LOAD_LBU: misaligned = 1'b0;
            LOAD_LH, LOAD_LHU: misaligned = stage.ex_result[0];
            default:           misaligned = (stage.ex_result[1:0] != 2'b00);
         endcase
      end
   end
   assign mem_adel = misaligned;
`else
   assign misaligned = 1'b0;
`endif

   // ID must never forward a value that is still being waited for.
   assign rf_we_out = stage.rf_we && !stallreq_for_mem && !misaligned;

   always_comb begin
      wb          = '0;
      wb.pc       = stage.pc;
      wb.rf_we    = rf_we_out;
      wb.rf_waddr = stage.rf_waddr;
      wb.rf_wdata = stage.sel_rf_res ? load_data : stage.ex_result;
   end

   assign mem_to_wb_bus = wb;
   assign mem_to_id_bus = wb;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic [5:0]  ext_stall;
   logic [5:0]  stall;
   logic [78:0] ex_bus;
   logic [31:0] rdata;
   logic        rvalid;
   logic [69:0] wb_bus;
   logic [69:0] id_bus;
   logic        stallreq;

   int n_checks = 0;
   int n_fail   = 0;

   // Pipeline controller model: a MEM stall request holds IF..WB.
   assign stall = stallreq ? 6'b011111 : ext_stall;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk              (clk),
      .resetn           (resetn),
      .stall            (stall),
      .ex_to_mem_bus    (ex_bus),
      .data_sram_rdata  (rdata),
      .data_sram_rvalid (rvalid),
      .mem_to_wb_bus    (wb_bus),
      .mem_to_id_bus    (id_bus),
      .stallreq_for_mem (stallreq)
   );

   function automatic logic [78:0] mk_ex(input logic [31:0] pc, input logic [2:0] op,
                                         input logic en, input logic [3:0] wen,
                                         input logic sel, input logic we,
                                         input logic [4:0] wa, input logic [31:0] res);
      return {pc, op, en, wen, sel, we, wa, res};
   endfunction

   function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                         input logic [4:0] wa, input logic [31:0] d);
      return {pc, we, wa, d};
   endfunction

   // Reference load extraction using plain arithmetic on the word value.
   function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] d);
      int unsigned b;
      int unsigned h;
      int unsigned w;
      w = d;
      b = (w / (1 << (8 * a))) % 256;
      h = (w / (1 << (16 * (a / 2)))) % 65536;
      case (op)
         3'd1:    return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
         3'd2:    return 32'(b);
         3'd3:    return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
         3'd4:    return 32'(h);
         default: return d;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      ext_stall = 6'b0;
      ex_bus    = mk_ex(32'hBFC00000, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h1000);
      rdata     = 32'h5555AAAA;
      rvalid    = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (wb_bus !== 70'h0) begin
         n_fail++; $display("FAIL reset_wb: got %h expected 0", wb_bus);
      end
      n_checks++;
      if (id_bus !== 70'h0) begin
         n_fail++; $display("FAIL reset_id: got %h expected 0", id_bus);
      end
      n_checks++;
      if (stallreq !== 1'b0) begin
         n_fail++; $display("FAIL reset_stallreq: got %b expected 0", stallreq);
      end
      ex_bus = '0;
      #1 resetn = 1'b1;
      tick();
   endtask

   // Load whose data is valid in the same cycle it sits in MEM.
   task automatic one_cycle_load(input string name, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] d,
                                 input logic [31:0] exp_d);
      logic [31:0] pc;
      logic [4:0]  wa;
      logic [69:0] exp;
      pc     = $urandom;
      wa     = 5'($urandom_range(1, 31));
      ex_bus = mk_ex(pc, op, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr);
      rdata  = d;
      rvalid = 1'b1;
      tick();
      exp = mk_wb(pc, 1'b1, wa, exp_d);
      n_checks++;
      if (wb_bus !== exp) begin
         n_fail++; $display("FAIL %s_wb: got %h expected %h", name, wb_bus, exp);
      end
      n_checks++;
      if (id_bus !== exp) begin
         n_fail++; $display("FAIL %s_id: got %h expected %h", name, id_bus, exp);
      end
      n_checks++;
      if (stallreq !== 1'b0) begin
         n_fail++; $display("FAIL %s_stallreq: got %b expected 0", name, stallreq);
      end
      // rvalid stays high into the next cycle, where only a nop sits in MEM.
      ex_bus = '0;
   endtask

   task automatic test_extract();
      one_cycle_load("lw",    3'b000, 32'h00001000, 32'h8899AABB, 32'h8899AABB);
      one_cycle_load("lb",    3'b001, 32'h00001003, 32'h80112233, 32'hFFFFFF80);
      one_cycle_load("lbu",   3'b010, 32'h00001003, 32'h80112233, 32'h00000080);
      one_cycle_load("lb0",   3'b001, 32'h00001000, 32'h80112233, 32'h00000033);
      one_cycle_load("lh",    3'b011, 32'h00001002, 32'hFFFE0001, 32'hFFFFFFFE);
      one_cycle_load("lhu",   3'b100, 32'h00001002, 32'hFFFE0001, 32'h0000FFFE);
      one_cycle_load("lh0",   3'b011, 32'h00001000, 32'hFFFE0001, 32'h00000001);
      one_cycle_load("op111", 3'b111, 32'h00001000, 32'h13572468, 32'h13572468);
      tick();
   endtask

   // Load whose data arrives in the lat-th cycle it sits in MEM.
   task automatic load_latency(input string name, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] d,
                               input int lat, input logic [31:0] exp_d);
      logic [31:0] pc;
      logic [4:0]  wa;
      logic [69:0] exp;
      int          stall_cycles;
      pc     = $urandom;
      wa     = 5'($urandom_range(1, 31));
      exp    = mk_wb(pc, 1'b1, wa, exp_d);
      ex_bus = mk_ex(pc, op, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr);
      rvalid = 1'b0;
      rdata  = $urandom;
      tick();
      ex_bus = '0;
      stall_cycles = 0;
      for (int c = 1; c <= lat; c++) begin
         if (c == lat) begin
            rvalid = 1'b1;
            rdata  = d;
         end
         #1;
         if (c < lat) begin
            if (stallreq === 1'b1) stall_cycles++;
            n_checks++;
            if (id_bus[37] !== 1'b0) begin
               n_fail++; $display("FAIL %s_fwd_we: got %b expected 0", name, id_bus[37]);
            end
            tick();
         end else begin
            n_checks++;
            if (wb_bus !== exp) begin
               n_fail++; $display("FAIL %s_wb: got %h expected %h", name, wb_bus, exp);
            end
            n_checks++;
            if (id_bus !== exp) begin
               n_fail++; $display("FAIL %s_id: got %h expected %h", name, id_bus, exp);
            end
         end
      end
      n_checks++;
      if (stall_cycles != lat - 1) begin
         n_fail++; $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cycles, lat - 1);
      end
      tick();
      rvalid = 1'b0;
   endtask

   task automatic test_latency();
      load_latency("lat3", 3'b000, 32'h00002004, 32'hCAFEF00D, 3, 32'hCAFEF00D);
      load_latency("lat2_lbu", 3'b010, 32'h00002001, 32'h0000A500, 2, 32'h000000A5);
   endtask

   // Data arrives during a downstream stall; it must survive until the stage moves.
   task automatic test_hold();
      logic [31:0] pc, pc2, res2, d;
      logic [4:0]  wa, wa2;
      logic [69:0] exp, exp2;
      pc = $urandom; pc2 = $urandom; res2 = $urandom; d = 32'h00C30000;
      wa = 5'd12; wa2 = 5'd13;
      exp  = mk_wb(pc, 1'b1, wa, 32'hFFFFFFC3);
      exp2 = mk_wb(pc2, 1'b1, wa2, res2);
      ext_stall = 6'b0;
      rvalid    = 1'b0;
      ex_bus    = mk_ex(pc, 3'b001, 1'b1, 4'h0, 1'b1, 1'b1, wa, 32'h00003002);
      tick();
      ext_stall = 6'b011111;
      rvalid    = 1'b1;
      rdata     = d;
      ex_bus    = mk_ex(pc2, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, wa2, res2);
      #1;
      n_checks++;
      if (wb_bus !== exp) begin
         n_fail++; $display("FAIL hold_first: got %h expected %h", wb_bus, exp);
      end
      tick();
      rvalid = 1'b0;
      rdata  = ~d;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (wb_bus !== exp) begin
            n_fail++; $display("FAIL hold_keep%0d: got %h expected %h", i, wb_bus, exp);
         end
         n_checks++;
         if (stallreq !== 1'b0) begin
            n_fail++; $display("FAIL hold_stallreq%0d: got %b expected 0", i, stallreq);
         end
         if (i < 3) tick();
      end
      ext_stall = 6'b0;
      tick();
      #1;
      n_checks++;
      if (wb_bus !== exp2) begin
         n_fail++; $display("FAIL hold_release: got %h expected %h", wb_bus, exp2);
      end
      ex_bus = '0;
      tick();
   endtask

   // A bubble while holding must drop the buffered data and return to normal operation.
   task automatic test_bubble_hold();
      logic [31:0] pc;
      ext_stall = 6'b0;
      rvalid    = 1'b0;
      ex_bus    = mk_ex(32'h11110000, 3'b000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h00004000);
      tick();
      ext_stall = 6'b011111;
      rvalid    = 1'b1;
      rdata     = 32'hAAAA5555;
      ex_bus    = '0;
      tick();
      rvalid    = 1'b0;
      ext_stall = 6'b001000;
      tick();
      #1;
      n_checks++;
      if (wb_bus !== 70'h0) begin
         n_fail++; $display("FAIL bubble_zero: got %h expected 0", wb_bus);
      end
      ext_stall = 6'b0;
      pc        = 32'h22220000;
      ex_bus    = mk_ex(pc, 3'b000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h00004100);
      rvalid    = 1'b1;
      rdata     = 32'h0F0F1234;
      tick();
      n_checks++;
      if (wb_bus !== mk_wb(pc, 1'b1, 5'd6, 32'h0F0F1234)) begin
         n_fail++; $display("FAIL bubble_next_load: got %h expected %h", wb_bus, mk_wb(pc, 1'b1, 5'd6, 32'h0F0F1234));
      end
      ex_bus = '0;
      tick();
      rvalid = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [31:0] pc;
      ext_stall = 6'b0;
      rvalid    = 1'b0;
      ex_bus    = mk_ex(32'h33330000, 3'b000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h00005000);
      tick();
      ex_bus = '0;
      tick();
      #1;
      n_checks++;
      if (stallreq !== 1'b1) begin
         n_fail++; $display("FAIL wait_stallreq: got %b expected 1", stallreq);
      end
      resetn = 1'b0;
      #1;
      n_checks++;
      if (wb_bus !== 70'h0 || id_bus !== 70'h0) begin
         n_fail++; $display("FAIL async_reset_bus: got %h/%h expected 0", wb_bus, id_bus);
      end
      n_checks++;
      if (stallreq !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_stallreq: got %b expected 0", stallreq);
      end
      rvalid = 1'b1;
      rdata  = 32'hDEADBEEF;
      tick();
      rvalid = 1'b0;
      resetn = 1'b1;
      pc     = 32'h44440000;
      ex_bus = mk_ex(pc, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h12345678);
      tick();
      n_checks++;
      if (wb_bus !== mk_wb(pc, 1'b1, 5'd3, 32'h12345678)) begin
         n_fail++; $display("FAIL post_reset_alu: got %h expected %h", wb_bus, mk_wb(pc, 1'b1, 5'd3, 32'h12345678));
      end
      n_checks++;
      if (stallreq !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_stallreq: got %b expected 0", stallreq);
      end
      ex_bus = '0;
      tick();
      one_cycle_load("post_reset_lw", 3'b000, 32'h00006000, 32'h0BADF00D, 32'h0BADF00D);
      tick();
   endtask

   task automatic test_random();
      logic [31:0] pc, res, d;
      logic [2:0]  op;
      logic [4:0]  wa;
      logic        we;
      logic        is_store;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            pc       = $urandom;
            res      = $urandom;
            op       = 3'($urandom_range(0, 7));
            wa       = 5'($urandom_range(0, 31));
            is_store = 1'($urandom_range(0, 1));
            we       = is_store ? 1'b0 : 1'($urandom_range(0, 1));
            ex_bus   = mk_ex(pc, op, is_store, is_store ? 4'hF : 4'h0, 1'b0, we, wa, res);
            rvalid   = 1'($urandom_range(0, 1));
            rdata    = $urandom;
            tick();
            n_checks++;
            if (wb_bus !== mk_wb(pc, we, wa, res)) begin
               n_fail++; $display("FAIL rand_alu%0d: got %h expected %h", i, wb_bus, mk_wb(pc, we, wa, res));
            end
            n_checks++;
            if (stallreq !== 1'b0) begin
               n_fail++; $display("FAIL rand_alu_stallreq%0d: got %b expected 0", i, stallreq);
            end
            ex_bus = '0;
            tick();
            rvalid = 1'b0;
         end else begin
            op  = 3'($urandom_range(0, 7));
            res = $urandom;
            d   = $urandom;
            load_latency("rand_load", op, res, d, $urandom_range(1, 4), ref_ext(op, res[1:0], d));
         end
      end
   endtask

   initial begin
      test_reset();
      test_extract();
      test_latency();
      test_hold();
      test_bubble_hold();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of EX.
- Registers the EX→MEM bus and accepts the data-SRAM read response for loads issued from EX.
- Extracts and extends load data, then drives the MEM→WB bus and the MEM→ID forwarding bus.
- Tolerates variable SRAM read latency: a 3-state FSM raises a stall request until load data is valid.

Parameters:
- EX_TO_MEM_WD, 79, input bus width: pc[78:47], load_op[46:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
- MEM_TO_WB_WD, 70, output bus width: pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0].
- STALL_WD, 6, stall bus width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- stall  in  STALL_WD  global stall vector; bit3 = MEM, bit4 = WB
- ex_to_mem_bus  in  EX_TO_MEM_WD  EX result bundle
- data_sram_rdata  in  32  SRAM read data
- data_sram_rvalid  in  1  read data valid, one-cycle pulse
- mem_to_wb_bus  out  MEM_TO_WB_WD  writeback bundle
- mem_to_id_bus  out  MEM_TO_WB_WD  forwarding copy, same content as mem_to_wb_bus
- stallreq_for_mem  out  1  1 = hold pipeline, load data pending

Behaviour:
- Reset: bus register, FSM and data buffer all clear.
  - State = IDLE.
  - All outputs 0, stallreq_for_mem = 0.
- Bus register update at posedge clk:
  - stall[3]=1 and stall[4]=0: load zero (bubble).
  - else stall[3]=0: capture ex_to_mem_bus.
  - else: hold.
- Load detection: is_load = data_ram_en & (data_ram_wen == 0). Stores pass through with rf_we as given (0).
- load_op encoding, using addr[1:0] = ex_result[1:0]:
  - 000 lw: whole word.
  - 001 lb: byte addr[1:0], sign-extended.
  - 010 lbu: same byte, zero-extended.
  - 011 lh: half addr[1], sign-extended.
  - 100 lhu: same half, zero-extended.
  - Other codes are treated as lw.
  - Byte lanes are little-endian: byte0 = rdata[7:0].
- rf_wdata selection: sel_rf_res = 1 → extracted load data; 0 → ex_result.
- FSM states:
  - IDLE: no load outstanding.
    - is_load and rvalid=0 → WAIT.
    - is_load and rvalid=1 and stall[3]=1 → capture rdata into buffer, go to HOLD.
    - is_load and rvalid=1 and stall[3]=0 → use rdata directly, remain IDLE.
  - WAIT: stallreq_for_mem = 1.
    - On rvalid: capture buffer.
    - Then go to IDLE if stall[3] deasserts that same cycle, else HOLD.
  - HOLD: buffer valid, data comes from buffer, stallreq = 0.
    - Return to IDLE when the register advances (stall[3]=0).
- stallreq_for_mem combinationally = is_load & ~rvalid & (state != HOLD).
  - rvalid in the same cycle clears the request; latency 0 extra cycles when SRAM answers in one.
- Boundary conditions:
  - rvalid with no load in MEM is ignored.
  - A bubble inserted while in HOLD returns the FSM to IDLE.
  - Async reset mid-WAIT: immediate IDLE, outstanding response discarded.
- Forwarding: mem_to_id_bus equals mem_to_wb_bus in the same cycle, including extracted load data.
  - While stallreq is high, rf_we on both buses is forced to 0 so ID never forwards garbage.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A misaligned access (lw with addr[1:0]≠0, lh/lhu with addr[0]=1) forces rf_we=0.
  - It also asserts an extra output port mem_adel (1 bit, reset 0), registered with the stage contents.
- Undefined:
  - No port and no check; the low address bits are used as-is for extraction.

Decomposition:
- Shared defines header: Stop/NoStop, bus widths, LOAD_OP codes (LW, LB, LBU, LH, LHU), FSM state encodings.
- One sub-module: mem_load_ext. Combinational; inputs load_op, addr[1:0], rdata; output the extended 32-bit word.

Test Plan:
- lw: addr 0x1000, rvalid same cycle, rdata 0x8899AABB → rf_wdata 0x8899AABB, stallreq never asserted.
- lb/lbu: addr low bits 2'b11, rdata 0x80112233.
  - lb → 0xFFFFFF80.
  - lbu → 0x00000080.
- lh: addr 2'b10, rdata 0xFFFE0001 → 0xFFFFFFFE; lhu → 0x0000FFFE.
- 3-cycle SRAM latency: stallreq high for exactly 2 cycles, mem_to_id_bus rf_we=0 during them, correct data on the third cycle.
- rvalid arrives while stall[3]=1 from a downstream stall: FSM→HOLD, data preserved after 4 stall cycles, then written back once.
- resetn pulled low in WAIT: outputs 0 asynchronously; after release a non-load ALU result 0x12345678 passes with no stall.
